rw_bus_initiator: RTL and testbench

RW_BUS_INITIATOR -- requirements
Module: rw_bus_initiator

---
 rtl/rw_bus_initiator.sv | 114 +++++++++++
 tb/tb_rw_bus_initiator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rw_bus_initiator.sv
// rw_bus_initiator
//   Turns one command from a local requester into a fixed-timing
//   SETUP/ACCESS/WAIT transfer on a simple chip-select bus. It then holds the
//   result in RESP until the requester takes it.
//
//   Ports
//     clk, reset_b              clock, async active-low reset
//     cmd_valid/ready           command handshake
//     cmd_write, cmd_addr, cmd_wdata   command fields
//     resp_valid/ready          response handshake
//     resp_write, resp_rdata    response fields (rdata is 0 for writes)
//     cs, write, bus_addr, bus_wdata, bus_rdata   responder bus
//     busy                      any state other than IDLE
//     xfer_count                completed transfers, wraps at 16 bits
module rw_bus_initiator #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_write,
    output logic [DW-1:0] resp_rdata,
    output logic          cs,
    output logic          write,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy,
    output logic [15:0]   xfer_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state;

    // cmd_ready is gated by reset_b. The state register already reads IDLE
    // while reset is held, but no command may be offered until release.
    assign cmd_ready = (state == IDLE) && reset_b;

    // Bus and handshake outputs are registered alongside the state. Each one
    // is loaded with the value its next state needs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            cs         <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            busy       <= 1'b0;
            xfer_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cs        <= 1'b1;
                        write     <= cmd_write;
                        bus_addr  <= cmd_addr;
                        bus_wdata <= cmd_wdata;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    state <= WAIT;
                    cs    <= 1'b0;
                end
                WAIT: begin
                    // write still carries the latched type here. The response
                    // takes it before it is dropped for RESP.
                    state      <= RESP;
                    write      <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_write <= write;
                    resp_rdata <= write ? '0 : bus_rdata;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        xfer_count <= xfer_count + 16'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cs         <= 1'b0;
                    write      <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rw_bus_initiator.sv
// tb_rw_bus_initiator
//   Directed scenarios followed by random traffic. A transaction-timeline
//   model tracks the cycles elapsed since a command was accepted and predicts
//   every DUT output on each falling edge.
module tb_rw_bus_initiator;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          cmd_ready, resp_valid, resp_write, cs, write, busy;
    logic [DW-1:0] resp_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;
    logic [15:0]   xfer_count;

    rw_bus_initiator #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_b(reset_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_write(resp_write), .resp_rdata(resp_rdata),
        .cs(cs), .write(write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .busy(busy), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: m_age counts edges since acceptance. Ages 1 and 2 have cs high,
    // age 3 is the responder cycle and age 4 waits for the consumer.
    bit            m_active;
    int            m_age;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_rwrite;
    logic [15:0]   m_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_age = 0; m_write = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_rwrite = 1'b0; m_count = 16'd0;
    endtask

    task automatic model_step();
        if (!m_active) begin
            if (cmd_valid) begin
                m_active = 1'b1; m_age = 1;
                m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
            end
        end else if (m_age < 4) begin
            if (m_age == 3) begin
                m_rwrite = m_write;
                m_rdata  = m_write ? '0 : bus_rdata;
            end
            m_age++;
        end else if (resp_ready) begin
            m_active = 1'b0;
            m_count  = m_count + 16'd1;
        end
    endtask

    // One clock: the model sees the same inputs as the DUT edge. Control
    // returns just after the falling edge, where new inputs are driven.
    task automatic step();
        @(posedge clk);
        if (reset_b) model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cs",         32'(cs),         32'(m_active && m_age >= 1 && m_age <= 2));
            chk("write",      32'(write),      32'(m_active && m_age >= 1 && m_age <= 3 && m_write));
            chk("resp_valid", 32'(resp_valid), 32'(m_active && m_age == 4));
            chk("busy",       32'(busy),       32'(m_active));
            chk("cmd_ready",  32'(cmd_ready),  32'(!m_active && reset_b));
            chk("bus_addr",   32'(bus_addr),   32'(m_addr));
            chk("bus_wdata",  32'(bus_wdata),  32'(m_wdata));
            chk("resp_write", 32'(resp_write), 32'(m_rwrite));
            chk("resp_rdata", 32'(resp_rdata), 32'(m_rdata));
            chk("xfer_count", 32'(xfer_count), 32'(m_count));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cs",        32'(cs),         32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready),  32'd0);
        chk("rst_count",     32'(xfer_count), 32'd0);
        reset_b = 1'b1;
        chk_en  = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write 0xA5 to 0x3C. bus_rdata is junk and must not leak into rdata.
        bus_rdata = 8'hFF; resp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h3C; cmd_wdata = 8'hA5;
        step();
        cmd_valid = 1'b0;
        chk("wr_setup_cs",   32'(cs),        32'd1);
        chk("wr_setup_wr",   32'(write),     32'd1);
        chk("wr_addr",       32'(bus_addr),  32'h3C);
        chk("wr_wdata",      32'(bus_wdata), 32'hA5);
        chk("wr_cmd_ready",  32'(cmd_ready), 32'd0);
        step();
        chk("wr_access_cs",  32'(cs),        32'd1);
        step();
        chk("wr_wait_cs",    32'(cs),        32'd0);
        chk("wr_wait_wr",    32'(write),     32'd1);
        step();
        chk("wr_resp_valid", 32'(resp_valid), 32'd1);
        chk("wr_resp_write", 32'(resp_write), 32'd1);
        chk("wr_resp_rdata", 32'(resp_rdata), 32'd0);
        step();
        chk("wr_count",      32'(xfer_count), 32'd1);
        chk("wr_mdl_count",  32'(m_count),    32'd1);
        chk("wr_idle_ready", 32'(cmd_ready),  32'd1);

        // Read 0x10 with 0x5A returned in WAIT, then hold off the response.
        resp_ready = 1'b0; bus_rdata = 8'h00;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("rd_wait_cs", 32'(cs), 32'd0);
        bus_rdata = 8'h5A;
        step();
        bus_rdata = 8'h00;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", 32'(resp_rdata), 32'h5A);
            chk("bp_rwrite", 32'(resp_write), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_count", 32'(xfer_count), 32'd1);
            if (k < 3) step();
        end
        chk("rd_mdl_rdata", 32'(m_rdata), 32'h5A);
        resp_ready = 1'b1;
        step();
        chk("bp_count_after", 32'(xfer_count), 32'd2);

        // Back-to-back: four transfers in 20 edges.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21; cmd_wdata = 8'h00;
        repeat (19) step();
        cmd_valid = 1'b0;
        step();
        chk("b2b_count", 32'(xfer_count), 32'd6);
        chk("b2b_mdl_count", 32'(m_count), 32'd6);
        chk("b2b_idle", 32'(cmd_ready), 32'd1);

        // Reset in ACCESS abandons the transfer.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h77; cmd_wdata = 8'h55;
        step();
        cmd_valid = 1'b0;
        step();
        chk("ra_access_cs", 32'(cs), 32'd1);
        reset_b = 1'b0;
        model_reset();
        #1;
        chk("ra_cs",         32'(cs),         32'd0);
        chk("ra_resp_valid", 32'(resp_valid), 32'd0);
        chk("ra_busy",       32'(busy),       32'd0);
        chk("ra_cmd_ready",  32'(cmd_ready),  32'd0);
        chk("ra_count",      32'(xfer_count), 32'd0);
        chk("ra_addr",       32'(bus_addr),   32'd0);
        step();
        reset_b = 1'b1;
        #1;
        chk("ra_rel_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("ra_next_count", 32'(xfer_count), 32'd1);
        chk("ra_next_rwrite", 32'(resp_write), 32'd1);

        // Counter wrap: preload all-ones and complete one more transfer.
        force dut.xfer_count = 16'hFFFF;
        #1;
        release dut.xfer_count;
        m_count = 16'hFFFF;
        chk("wrap_pre", 32'(xfer_count), 32'hFFFF);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("wrap_count", 32'(xfer_count), 32'd0);
        chk("wrap_mdl", 32'(m_count), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            cmd_valid  = ($urandom_range(0, 3) != 0);
            cmd_write  = 1'($urandom_range(0, 1));
            cmd_addr   = 8'($urandom);
            cmd_wdata  = 8'($urandom);
            bus_rdata  = 8'($urandom);
            resp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        cmd_valid = 1'b0; resp_ready = 1'b1;
        repeat (6) step();
        chk("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
